vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Drives the VGA port: generates 640x480@60 Hz raster timing, presents the current pixel coordinate to the pixel-source block (sprite/background mux), and registers the returned 32-bit color word onto the RGB pins.
- It is the requesting end of the pixelX/pixelY -> dato interface, so it has to absorb the source's registered read latency.
- Sits between the pixel-source block and the board DAC pins (hsync, vsync, RGB, blank_n, sync_n).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync pulse width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
DATA_LATENCY, 1, pixel-source latency in ticks from pixelX/pixelY to dato (range 1..4)

Ports:
clk  input  1  system clock; equals pixel clock (25 MHz) unless CLK_DIV2_EN
rst_n  input  1  asynchronous active-low reset
dato  input  32  color from pixel source, 0x00RRGGBB (bits 31:24 ignored)
pixelX  output  10  current column to pixel source
pixelY  output  10  current line to pixel source
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
red  output  8  red channel, dato[23:16]
green  output  8  green channel, dato[15:8]
blue  output  8  blue channel, dato[7:0]
blank_n  output  1  high while RGB carries visible data
sync_n  output  1  DAC composite sync, tied 0
frame_start  output  1  one-tick pulse at h_cnt=0, v_cnt=0

Behaviour:
- Tick: the pixel-rate enable. Tick = 1 every clk unless CLK_DIV2_EN. All counter and pipeline state advances only on a tick.
- H_TOTAL = 800, V_TOTAL = 525 with defaults; both are derived from the parameters.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- On the h wrap, v_cnt increments, covering 0..V_TOTAL-1 and wrapping to 0. At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, both counters go to 0 on the same tick.
- active = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- pixelX/pixelY are registered and equal h_cnt/v_cnt on the same tick, with no delay. They read 0 when the respective axis is outside its visible range (pixelX=0 for h_cnt>=640; pixelY=0 for v_cnt>=480).
- Sync decode, counter stage:
  - hs_raw is low for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw is low for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491). vs_raw changes only with v_cnt, so it is line-aligned.
- Alignment pipeline: active, hs_raw and vs_raw pass through a shift register of DATA_LATENCY stages. The output register stage adds one more.
  - hsync, vsync, blank_n and RGB therefore all correspond to the counter value from DATA_LATENCY+1 ticks earlier.
  - RGB is loaded with dato fields when the delayed active is 1, else 0x00.
  - blank_n = delayed active.
- frame_start is asserted during the tick where h_cnt=0 and v_cnt=0, aligned with pixelX/pixelY, not delayed.
- Reset (asynchronous assert, synchronous to clk on deassert):
  - h_cnt=0, v_cnt=0, pixelX=0, pixelY=0.
  - hsync=1, vsync=1, red/green/blue=0, blank_n=0, frame_start=0, all delay stages inactive.
  - The first tick after release shows counter (0,0). Reset mid-frame abandons the frame with no partial-line completion.
- dato content is not checked; X on dato while blanked must not reach the RGB pins.
- Outputs are glitch-free: every output is a flop, except sync_n, which is a constant.

Optional Feature:
- Macro: CLK_DIV2_EN.
- Defined: clk is 50 MHz. An internal toggle flop (reset 0) produces tick on every second clk. All outputs hold for 2 clk per pixel. DATA_LATENCY stays counted in ticks; the pixel source samples pixelX on clk, which is valid because pixelX is stable for 2 clk.
- Undefined: tick is constant 1 and there is no divider flop.

Test Plan:
1. Reset: hold rst_n=0 for 5 clk with dato=0xFFFFFF -> hsync=1, vsync=1, RGB=0, blank_n=0, pixelX=0, pixelY=0. Release -> frame_start=1 on the first tick.
2. Line timing: run 2 lines -> hsync low exactly 96 ticks, falling edge 656+DATA_LATENCY+1 ticks after h_cnt=0. Period 800 ticks; pixelX steps 0..639, then holds 0 for 160 ticks.
3. Frame timing: run 1 frame -> vsync low for 2x800 ticks starting line 490. frame_start period 420000 ticks; pixelY reaches 479 max.
4. Latency alignment: bench models the source as dato = {8'h0, pixelY[7:0], pixelX[7:0], 8'h5A} delayed DATA_LATENCY ticks -> at the first blank_n=1 tick RGB = (00,00,5A). For pixel (37,12), RGB = (0C,25,5A).
5. Blanking: dato=0x56B000 constant -> RGB=0 and blank_n=0 throughout h_cnt 640..799 and lines 480..524. Visible pixels show (56,B0,00).
6. Mid-frame reset: assert rst_n=0 asynchronously (not on a clk edge) at line 200, pixel 300 -> outputs reach reset values immediately. After release, counting restarts at (0,0); with CLK_DIV2_EN, each pixel holds 2 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinate request, latency-aligned sync/blank and RGB output register.
// Optional CLK_DIV2_EN: clk runs at twice the pixel rate and an internal toggle flop provides the pixel tick.
module vga_timing_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int DATA_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dato,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic                    tick_s;
  logic                    run_r;
  logic [9:0]              h_cnt_r;
  logic [9:0]              v_cnt_r;
  logic [9:0]              h_nxt_s;
  logic [9:0]              v_nxt_s;
  logic                    act_s;
  logic                    hs_s;
  logic                    vs_s;
  logic [DATA_LATENCY-1:0] act_d_r;
  logic [DATA_LATENCY-1:0] hs_d_r;
  logic [DATA_LATENCY-1:0] vs_d_r;
  logic                    dato_unused_s;

  assign sync_n        = 1'b0;
  assign dato_unused_s = ^dato[31:24];

`ifdef CLK_DIV2_EN
  logic tick_r;

  // Pixel-rate enable: every second clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= ~tick_r;
    end
  end

  assign tick_s = tick_r;
`else
  assign tick_s = 1'b1;
`endif

  // Next raster position; the first tick after reset lands on (0,0)
  always_comb begin
    h_nxt_s = 10'd0;
    v_nxt_s = 10'd0;
    if (!run_r) begin
      h_nxt_s = 10'd0;
      v_nxt_s = 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_nxt_s = 10'd0;
      v_nxt_s = (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
    end else begin
      h_nxt_s = h_cnt_r + 10'd1;
      v_nxt_s = v_cnt_r;
    end
  end

  // Counter-stage decode; the pre-start state is treated as blanked
  always_comb begin
    act_s = run_r && (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    hs_s  = !(run_r && (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
    vs_s  = !(run_r && (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
  end

  // Counters, coordinate request, alignment pipeline and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      h_cnt_r     <= 10'd0;
      v_cnt_r     <= 10'd0;
      pixelX      <= 10'd0;
      pixelY      <= 10'd0;
      frame_start <= 1'b0;
      act_d_r     <= '0;
      hs_d_r      <= '1;
      vs_d_r      <= '1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
    end else if (tick_s) begin
      run_r       <= 1'b1;
      h_cnt_r     <= h_nxt_s;
      v_cnt_r     <= v_nxt_s;
      pixelX      <= (h_nxt_s < H_VIS) ? h_nxt_s : 10'd0;
      pixelY      <= (v_nxt_s < V_VIS) ? v_nxt_s : 10'd0;
      frame_start <= (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
      act_d_r[0]  <= act_s;
      hs_d_r[0]   <= hs_s;
      vs_d_r[0]   <= vs_s;
      for (int i = 1; i < DATA_LATENCY; i++) begin
        act_d_r[i] <= act_d_r[i-1];
        hs_d_r[i]  <= hs_d_r[i-1];
        vs_d_r[i]  <= vs_d_r[i-1];
      end
      hsync   <= hs_d_r[DATA_LATENCY-1];
      vsync   <= vs_d_r[DATA_LATENCY-1];
      blank_n <= act_d_r[DATA_LATENCY-1];
      // Blanked pixels never pass dato through, so undefined source data stays off the pins
      if (act_d_r[DATA_LATENCY-1]) begin
        red   <= dato[23:16];
        green <= dato[15:8];
        blue  <= dato[7:0];
      end else begin
        red   <= 8'h00;
        green <= 8'h00;
        blue  <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so full frames stay short.
module tb_vga_timing_gen;

  localparam int HV = 64, HF = 8, HS = 12, HB = 6;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 40, VF = 3, VS = 2, VB = 4;
  localparam int VT = VV + VF + VS + VB;
  localparam int LAT = 2;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dato;
  logic [9:0]  pixelX, pixelY;
  logic        hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0]  red, green, blue;

  int          src_mode = 2;
  logic [31:0] src_q [LAT];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int         mode;
    int         h;
    int         v;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       bl;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs [15];

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .DATA_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dato(dato),
    .pixelX(pixelX), .pixelY(pixelY),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .blank_n(blank_n), .sync_n(sync_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Pixel source model: registered lookup of the requested coordinate, LAT ticks deep
  always @(posedge clk) begin
    src_q[0] <= {8'h00, pixelY[7:0], pixelX[7:0], 8'h5A};
    for (int i = 1; i < LAT; i++) src_q[i] <= src_q[i-1];
  end

  assign dato = (src_mode == 1) ? 32'h0056B000 :
                (src_mode == 2) ? 32'h00FFFFFF : src_q[LAT-1];

  function automatic logic [26:0] exp_out(input int c, input int mode);
    int h = c % HT;
    int v = c / HT;
    logic a;
    logic [7:0] hb, vb;
    logic [23:0] col;
    a = (h < HV) && (v < VV);
    hb = 8'(h);
    vb = 8'(v);
    col = (mode == 0) ? {vb, hb, 8'h5A} : (mode == 1) ? 24'h56B000 : 24'hFFFFFF;
    return {!((h >= HV + HF) && (h < HV + HF + HS)),
            !((v >= VV + VF) && (v < VV + VF + VS)),
            a, a ? col : 24'h000000};
  endfunction

  function automatic logic [20:0] exp_pix(input int c);
    int h = c % HT;
    int v = c / HT;
    return {(h < HV) ? 10'(h) : 10'd0, (v < VV) ? 10'(v) : 10'd0, (h == 0) && (v == 0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [26:0] rst_out;
  logic [26:0] sb [$];
  logic [26:0] exp_q;
  int hs_run, hs_last, vs_run, vs_last, fs_cnt, fs_first, fs_second, max_y, hs_fall;
  logic hs_prev;

  initial begin
    rst_out = {1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[0]  = '{0,  0,  0, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{0, 37, 12, 8'h0C, 8'h25, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{0, 63, 39, 8'h27, 8'h3F, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{0, 64, 12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{0,  5, 40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1, 10, 10, 8'h56, 8'hB0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1, 89, 48, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1, 71,  3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1, 72,  3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1, 83,  3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1, 84,  3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1,  0, 43, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1, 89, 44, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1,  0, 45, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{2, 20, 20, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};

    // Reset values with a bright source present
    src_mode = 2;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outputs", 64'({pixelX, pixelY, frame_start, hsync, vsync, blank_n, red, green, blue}),
        64'({10'd0, 10'd0, 1'b0, rst_out}));
    chk("sync_n", 64'(sync_n), 64'd0);

    // Two full frames against the arithmetic model, outputs through a scoreboard
    src_mode = 0;
    rst_n = 1'b1;
    for (int i = 0; i <= LAT; i++) sb.push_back(rst_out);
    hs_run = 0; hs_last = 0; vs_run = 0; vs_last = 0; fs_cnt = 0;
    fs_first = 0; fs_second = 0; max_y = 0; hs_fall = 0; hs_prev = 1'b1;
    for (int k = 1; k <= 2 * FRAME + 10; k++) begin
      @(posedge clk);
      sb.push_back(exp_out((k - 1) % FRAME, 0));
      @(negedge clk);
      exp_q = sb.pop_front();
      chk("stream_pixel", 64'({pixelX, pixelY, frame_start}), 64'(exp_pix((k - 1) % FRAME)));
      chk("stream_out", 64'({hsync, vsync, blank_n, red, green, blue}), 64'(exp_q));
      if (!hsync) hs_run++;
      else begin
        if (hs_run > 0) hs_last = hs_run;
        hs_run = 0;
      end
      if (!vsync) vs_run++;
      else begin
        if (vs_run > 0) vs_last = vs_run;
        vs_run = 0;
      end
      if (!hsync && hs_prev && hs_fall == 0) hs_fall = k;
      hs_prev = hsync;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = k;
        else if (fs_cnt == 2) fs_second = k;
      end
      if (int'(pixelY) > max_y) max_y = int'(pixelY);
      if (n_fail > 30) break;
    end
    chk("hsync_width", 64'(hs_last), 64'(HS));
    chk("hsync_fall_tick", 64'(hs_fall - fs_first), 64'(HV + HF + LAT + 1));
    chk("vsync_width", 64'(vs_last), 64'(VS * HT));
    chk("frame_period", 64'(fs_second - fs_first), 64'(FRAME));
    chk("frame_count", 64'(fs_cnt), 64'd3);
    chk("max_pixelY", 64'(max_y), 64'(VV - 1));

    // Table of probed pixels, each from a fresh reset
    for (int i = 0; i < 15; i++) begin
      do_reset(3);
      src_mode = vecs[i].mode;
      repeat (vecs[i].v * HT + vecs[i].h + LAT + 2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d(%0d,%0d)", i, vecs[i].h, vecs[i].v),
          64'({hsync, vsync, blank_n, red, green, blue}),
          64'({vecs[i].hs, vecs[i].vs, vecs[i].bl, vecs[i].r, vecs[i].g, vecs[i].b}));
    end

    // Asynchronous reset in the middle of a visible line, then restart
    do_reset(3);
    src_mode = 0;
    repeat (20 * HT + 30 + 1) @(posedge clk);
    #1;
    chk("pre_reset_pos", 64'({pixelX, pixelY, blank_n}), 64'({10'd30, 10'd20, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({pixelX, pixelY, frame_start, hsync, vsync, blank_n, red, green, blue}),
        64'({10'd0, 10'd0, 1'b0, rst_out}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("restart_pixel", 64'({pixelX, pixelY, frame_start}), 64'(exp_pix(k - 1)));
      chk("restart_out", 64'({hsync, vsync, blank_n, red, green, blue}),
          (k <= LAT + 1) ? 64'(rst_out) : 64'(exp_out(k - LAT - 2, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
